// File: rtl/rc_settle_monitor.sv
// rtl/rc_settle_monitor.sv - step-response settling time and overshoot monitor for the RC model output
// Samples v_out every cycle after start; reports settle index, timeout and peak overshoot.
module rc_settle_monitor #(
  parameter int WIDTH      = 25,
  parameter int CNT_W      = 16,
  parameter int HOLD       = 4,
  parameter int MAX_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] v_out,
  input  logic signed [WIDTH-1:0] target,
  input  logic        [WIDTH-2:0] tol,
  output logic                    busy,
  output logic                    done,
  output logic                    settled,
  output logic                    timeout,
  output logic        [CNT_W-1:0] settle_cycles,
  output logic signed [WIDTH-1:0] max_overshoot
);

  localparam int HW = $clog2(HOLD + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [HW-1:0]           HOLD_N    = HW'(HOLD);
  localparam logic [CNT_W-1:0]        K_LAST    = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]        K_TIMEOUT = CNT_W'(MAX_CYCLES);
  localparam logic signed [WIDTH:0]   OS_SAT    = {2'b00, {(WIDTH-1){1'b1}}};

  logic [1:0]              state;
  logic signed [WIDTH-1:0] target_q;
  logic [WIDTH-2:0]        tol_q;
  logic [CNT_W-1:0]        k;
  logic [CNT_W-1:0]        entry;
  logic [HW-1:0]           hold_cnt;

  logic signed [WIDTH:0]   err;
  logic [WIDTH:0]          abs_err;
  logic                    in_band;
  logic [HW-1:0]           hold_nxt;
  logic [CNT_W-1:0]        entry_nxt;
  logic                    settle_hit;
  logic                    last_sample;
  logic                    os_upd;
  logic [WIDTH-1:0]        os_cand;

  // One extra bit keeps the difference of two full-range operands exact.
  always_comb begin
    err         = $signed({v_out[WIDTH-1], v_out}) - $signed({target_q[WIDTH-1], target_q});
    abs_err     = err[WIDTH] ? $unsigned(-err) : $unsigned(err);
    in_band     = (abs_err <= {2'b00, tol_q});
    hold_nxt    = '0;
    if (in_band) begin
      hold_nxt = (hold_cnt == HOLD_N) ? HOLD_N : hold_cnt + HW'(1);
    end
    entry_nxt   = (in_band && (hold_cnt == '0)) ? k : entry;
    settle_hit  = in_band && (hold_nxt == HOLD_N);
    last_sample = (k == K_LAST);
    os_upd      = (err > $signed({1'b0, max_overshoot}));
    os_cand     = (err > OS_SAT) ? OS_SAT[WIDTH-1:0] : err[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      target_q      <= '0;
      tol_q         <= '0;
      k             <= '0;
      entry         <= '0;
      hold_cnt      <= '0;
      settled       <= 1'b0;
      timeout       <= 1'b0;
      settle_cycles <= '0;
      max_overshoot <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            target_q      <= target;
            tol_q         <= tol;
            k             <= '0;
            entry         <= '0;
            hold_cnt      <= '0;
            settled       <= 1'b0;
            timeout       <= 1'b0;
            settle_cycles <= '0;
            max_overshoot <= '0;
            state         <= S_TRACK;
          end
        end
        S_TRACK: begin
          hold_cnt <= hold_nxt;
          entry    <= entry_nxt;
          if (os_upd) begin
            max_overshoot <= os_cand;
          end
          // Settling on the final sample takes priority over timing out.
          if (settle_hit) begin
            settle_cycles <= entry_nxt;
            settled       <= 1'b1;
            state         <= S_REPORT;
          end else if (last_sample) begin
            settle_cycles <= K_TIMEOUT;
            timeout       <= 1'b1;
            state         <= S_REPORT;
          end else begin
            k <= k + CNT_W'(1);
          end
        end
        S_REPORT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == S_TRACK);
  assign done = (state == S_REPORT);

endmodule

// File: tb/tb_rc_settle_monitor.sv
// tb/tb_rc_settle_monitor.sv - randomized and directed bench for rc_settle_monitor
// Two instances (HOLD=4 and HOLD=1) see the same stimulus and are scored against a window-search model.
module tb_rc_settle_monitor;

  localparam int W    = 16;
  localparam int CW   = 8;
  localparam int MAXC = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                start;
  logic signed [W-1:0] v_out;
  logic signed [W-1:0] target;
  logic [W-2:0]        tol;

  logic [1:0]          busy;
  logic [1:0]          done;
  logic [1:0]          settled;
  logic [1:0]          timeout;
  logic [1:0][CW-1:0]  sc;
  logic [1:0][W-1:0]   mos;

  int n_vec = 0;
  int n_err = 0;
  int s[MAXC];
  int tgt;
  int tl;
  int q[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rc_settle_monitor #(
      .WIDTH(W), .CNT_W(CW), .HOLD((g == 0) ? 4 : 1), .MAX_CYCLES(MAXC)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .v_out(v_out), .target(target), .tol(tol),
      .busy(busy[g]), .done(done[g]), .settled(settled[g]), .timeout(timeout[g]),
      .settle_cycles(sc[g]), .max_overshoot(mos[g])
    );
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int hold_of(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic load(input int qq[$]);
    for (int i = 0; i < MAXC; i++) s[i] = (i < qq.size()) ? qq[i] : qq[qq.size() - 1];
  endtask

  // Settles at the first sample that closes a window of `hold` consecutive in-band samples.
  task automatic model(input int hold, output int dk, output int st, output int to,
                       output int scx, output int os);
    int all_in;
    int e;
    st = 0; dk = MAXC - 1; scx = MAXC;
    for (int kk = hold - 1; kk < MAXC && st == 0; kk++) begin
      all_in = 1;
      for (int j = kk - hold + 1; j <= kk; j++)
        if (iabs(s[j] - tgt) > tl) all_in = 0;
      if (all_in == 1) begin
        st = 1; dk = kk; scx = kk - hold + 1;
      end
    end
    to = (st == 0) ? 1 : 0;
    os = 0;
    for (int kk = 0; kk <= dk; kk++) begin
      e = s[kk] - tgt;
      if (e > os) os = e;
    end
    if (os > 32767) os = 32767;
  endtask

  task automatic check_idle(input string name);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("%s/h%0d busy", name, hold_of(g)), int'(busy[g]), 0);
      check_eq($sformatf("%s/h%0d done", name, hold_of(g)), int'(done[g]), 0);
      check_eq($sformatf("%s/h%0d settled", name, hold_of(g)), int'(settled[g]), 0);
      check_eq($sformatf("%s/h%0d timeout", name, hold_of(g)), int'(timeout[g]), 0);
      check_eq($sformatf("%s/h%0d settle_cycles", name, hold_of(g)), int'(sc[g]), 0);
      check_eq($sformatf("%s/h%0d max_overshoot", name, hold_of(g)), int'(mos[g]), 0);
    end
  endtask

  task automatic run_case(input string name, input int rst_at, input bit poke);
    int dk_seen[2];
    int dcnt[2];
    int edk, est, eto, esc, eos;
    int t;
    @(posedge clk); #1;
    target = 16'(tgt);
    tol    = 15'(tl);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    target = 16'(0);
    tol    = 15'(0);
    t      = 0;
    v_out  = 16'(s[0]);
    for (int g = 0; g < 2; g++) begin
      dk_seen[g] = -1;
      dcnt[g]    = 0;
      check_eq($sformatf("%s/h%0d busy_at_start", name, hold_of(g)), int'(busy[g]), 1);
    end
    for (int it = 0; it < MAXC + 3; it++) begin
      if (rst_at == t) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle({name, "/after_rst"});
        return;
      end
      if (poke && t == 5) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int g = 0; g < 2; g++) begin
        if (done[g]) begin
          dcnt[g]++;
          if (dk_seen[g] < 0) dk_seen[g] = t;
          check_eq($sformatf("%s/h%0d busy_in_done", name, hold_of(g)), int'(busy[g]), 0);
        end
      end
      t++;
      v_out = 16'((t < MAXC) ? s[t] : s[MAXC - 1]);
    end
    for (int g = 0; g < 2; g++) begin
      model(hold_of(g), edk, est, eto, esc, eos);
      check_eq($sformatf("%s/h%0d done_sample", name, hold_of(g)), dk_seen[g], edk);
      check_eq($sformatf("%s/h%0d done_pulses", name, hold_of(g)), dcnt[g], 1);
      check_eq($sformatf("%s/h%0d settled", name, hold_of(g)), int'(settled[g]), est);
      check_eq($sformatf("%s/h%0d timeout", name, hold_of(g)), int'(timeout[g]), eto);
      check_eq($sformatf("%s/h%0d settle_cycles", name, hold_of(g)), int'(sc[g]), esc);
      check_eq($sformatf("%s/h%0d max_overshoot", name, hold_of(g)), int'(mos[g]), eos);
    end
  endtask

  initial begin
    int sp;
    rst = 1'b1; start = 1'b0; v_out = '0; target = '0; tol = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst = 1'b0;

    tgt = 1000; tl = 10;
    q = '{0, 200, 400, 600, 800, 1000};
    load(q); run_case("ramp", -1, 1'b0);
    q = '{0, 1100, 1050, 1005, 1000};
    load(q); run_case("overshoot", -1, 1'b0);
    q = '{0, 500, 1000, 1000, 1020, 1000};
    load(q); run_case("ringing", -1, 1'b0);
    q = '{0};
    load(q); run_case("timeout", -1, 1'b1);

    tgt = -500; tl = 20;
    q = '{-520};
    load(q); run_case("edge_in", -1, 1'b0);
    q = '{-521};
    load(q); run_case("edge_out", -1, 1'b0);

    tgt = 1000; tl = 10;
    q = '{0, 200, 400, 600, 800, 1000};
    load(q); run_case("ramp_rst", 3, 1'b0);
    run_case("ramp_again", -1, 1'b0);

    tgt = -30000; tl = 100;
    q = '{30000};
    load(q); run_case("saturate", -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      tgt = int'($urandom_range(0, 4000)) - 2000;
      tl  = int'($urandom_range(0, 40));
      sp  = int'($urandom_range(0, MAXC));
      for (int kk = 0; kk < MAXC; kk++) begin
        if (kk < sp) s[kk] = tgt + int'($urandom_range(0, 600)) - 300;
        else         s[kk] = tgt + int'($urandom_range(0, 2 * (tl + 2))) - (tl + 2);
      end
      run_case($sformatf("rand%0d", i), -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
